// File: rtl/fe_hit_collector.sv
// Front-end hit collector: tags up to three hits per BX with bx/slot
// and streams them out one per cycle through a 3-write/1-read FIFO.
module fe_hit_collector #(
  parameter int DEPTH = 16,
  parameter int BX_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       hit1_dv,
  input  logic [12:0]                hit1_data,
  input  logic                       hit2_dv,
  input  logic [12:0]                hit2_data,
  input  logic                       hit3_dv,
  input  logic [12:0]                hit3_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BX_W+14:0]           out_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int DW = BX_W + 15;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic [BX_W-1:0] bx_cnt;

  logic [2:0]      req;
  logic [2:0]      acc;
  logic [1:0]      pos [3];
  logic [AW-1:0]   addr [3];
  logic [DW-1:0]   entry [3];
  logic [12:0]     data [3];
  logic [OW-1:0]   free;
  logic [1:0]      n_req;
  logic [1:0]      n_acc;
  logic [1:0]      n_drop;
  logic [16:0]     drop_sum;
  logic            pop;

  assign data[0] = hit1_data;
  assign data[1] = hit2_data;
  assign data[2] = hit3_data;

  assign req  = {3{en}} & {hit3_dv, hit2_dv, hit1_dv};
  assign free = OW'(DEPTH) - occ;

  // Requests pack into consecutive locations; a slot is kept only if its
  // rank among this cycle's requests fits in the free space.
  always_comb begin
    pos[0] = 2'd0;
    pos[1] = {1'b0, req[0]};
    pos[2] = 2'(req[0]) + 2'(req[1]);
    n_req  = 2'(req[0]) + 2'(req[1]) + 2'(req[2]);
    acc    = '0;
    n_acc  = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k]  = wr_ptr + AW'(pos[k]);
      entry[k] = {bx_cnt, 2'(k + 1), data[k]};
      acc[k]   = req[k] && (OW'(pos[k]) < free);
      n_acc    = n_acc + 2'(acc[k]);
    end
    n_drop   = n_req - n_acc;
    drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
  end

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) mem[addr[k]] <= entry[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      bx_cnt   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_acc);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OW'(n_acc) - OW'(pop);
      if (en) bx_cnt <= bx_cnt + BX_W'(1);
      if (n_drop != '0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_fe_hit_collector.sv
// Scoreboard bench for fe_hit_collector: directed BX vectors push the
// hand-derived expected outputs; a negedge monitor pops and compares.
module tb_fe_hit_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        hit1_dv = 1'b0, hit2_dv = 1'b0, hit3_dv = 1'b0;
  logic [12:0] hit1_data = '0, hit2_data = '0, hit3_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] out_data;
  logic [4:0]  occupancy;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  logic [22:0] exp_q [$];

  fe_hit_collector #(.DEPTH(16), .BX_W(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .hit1_dv(hit1_dv), .hit1_data(hit1_data),
    .hit2_dv(hit2_dv), .hit2_data(hit2_data),
    .hit3_dv(hit3_dv), .hit3_data(hit3_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] tag(input int bx, input int slot,
                                      input logic [12:0] d);
    return {8'(bx), 2'(slot), d};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs, then return #1 after the edge.
  task automatic drive(input logic r, input logic e,
                       input logic v1, input logic [12:0] d1,
                       input logic v2, input logic [12:0] d2,
                       input logic v3, input logic [12:0] d3,
                       input logic rdy);
    rst = r; en = e; out_ready = rdy;
    hit1_dv = v1; hit1_data = d1;
    hit2_dv = v2; hit2_data = d2;
    hit3_dv = v3; hit3_data = d3;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, '0, 0, '0, 0, '0, rdy);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    idle(0, 0);
    drive(1, 0, 0, '0, 0, '0, 0, '0, 0);
    drive(1, 0, 0, '0, 0, '0, 0, '0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);

    // single hit, bx 0
    exp_q.push_back(tag(0, 1, 13'h0ABC));
    drive(0, 1, 1, 13'h0ABC, 0, '0, 0, '0, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_occ", occupancy, 1);
    chk("t1_data", out_data, tag(0, 1, 13'h0ABC));
    idle(1, 1);
    chk("t1_occ0", occupancy, 0);

    // three slots, bx 1
    for (int s = 1; s <= 3; s++) exp_q.push_back(tag(1, s, 13'(s)));
    drive(0, 1, 1, 13'd1, 1, 13'd2, 1, 13'd3, 1);
    chk("t2_occ", occupancy, 3);
    idle(4, 1);
    chk("t2_occ0", occupancy, 0);

    // fill with ready low: bx 2..7, last BX keeps only slot 1
    for (int b = 0; b < 6; b++) begin
      for (int s = 1; s <= 3; s++)
        if (b < 5 || s == 1)
          exp_q.push_back(tag(2 + b, s, 13'(16 * b + s)));
      drive(0, 1, 1, 13'(16 * b + 1), 1, 13'(16 * b + 2),
            1, 13'(16 * b + 3), 0);
    end
    chk("t3_occ", occupancy, 16);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_ovf", overflow, 1);
    idle(2, 0);
    chk("t3_hold", out_data, tag(2, 1, 13'd1));

    // full, ready high, one hit per BX (bx 8..11): only bx 8 is dropped
    drive(0, 1, 1, 13'h100, 0, '0, 0, '0, 1);
    chk("t4_occ_a", occupancy, 15);
    chk("t4_drop_a", drop_cnt, 3);
    for (int b = 9; b <= 11; b++) begin
      exp_q.push_back(tag(b, 1, 13'(b)));
      drive(0, 1, 1, 13'(b), 0, '0, 0, '0, 1);
    end
    chk("t4_occ_b", occupancy, 15);
    chk("t4_drop_b", drop_cnt, 3);
    idle(20, 1);
    chk("t4_occ0", occupancy, 0);

    // 256 BXs from bx 12: tag wraps ff -> 00
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(tag((12 + i) % 256, 2, 13'(i)));
      drive(0, 1, 0, '0, 1, 13'(i), 0, '0, 1);
    end
    idle(3, 1);
    exp_q.push_back(tag(12, 3, 13'h1FFF));
    drive(0, 1, 0, '0, 0, '0, 1, 13'h1FFF, 1);
    idle(3, 1);
    chk("t5_occ0", occupancy, 0);
    chk("t5_drop", drop_cnt, 3);

    // reset with 7 buffered hits discards them
    drive(0, 1, 1, 13'd1, 1, 13'd2, 1, 13'd3, 0);
    drive(0, 1, 1, 13'd1, 1, 13'd2, 1, 13'd3, 0);
    drive(0, 1, 1, 13'd1, 0, '0, 0, '0, 0);
    chk("t6_occ7", occupancy, 7);
    drive(1, 1, 1, 13'd5, 1, 13'd6, 1, 13'd7, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_occ", occupancy, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_ovf", overflow, 0);
    exp_q.push_back(tag(0, 1, 13'h0055));
    drive(0, 1, 1, 13'h0055, 0, '0, 0, '0, 1);
    idle(3, 1);
    chk("t6_occ0", occupancy, 0);

    chk("sb_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
